mem_copy_dma: RTL and testbench
===============================

Name: mem_copy_dma

Overview:
- Bus initiator for the on-chip native memory bus (valid/ready/wstrb/addr/wdata/rdata, single outstanding transfer).
- Copies LEN 32-bit words from a source region to a destination region, or fills a destination region with a constant pattern.
- Sits beside the CPU as a second bus master, behind the arbiter, and drives the same RAM/peripheral responders the CPU uses.
- Controlled by a start pulse; reports busy, done, error and words moved.

Parameters:
- LEN_W, 16, width of the word-count input and transfer counter.
- TIMEOUT, 1024, max cycles mem_valid may stay high without mem_ready before abort (must be >= 2).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- fill  input  1  1 = fill mode (no reads), 0 = copy mode; sampled with start
- src_addr  input  32  source byte address; bits[1:0] ignored
- dst_addr  input  32  destination byte address; bits[1:0] ignored
- len  input  LEN_W  number of words
- pattern  input  32  fill word; sampled with start
- busy  output  1  high from the cycle after start until done/error
- done  output  1  one-cycle pulse on successful completion
- error  output  1  sticky timeout flag; cleared by the next accepted start
- xfer_count  output  LEN_W  words written so far in the current or last job
- mem_valid  output  1  bus request
- mem_ready  input  1  responder completion
- mem_wstrb  output  4  0 = read, 4'hF = write
- mem_addr  output  32  word-aligned byte address, bits[1:0] always 0
- mem_wdata  output  32  write data
- mem_rdata  input  32  read data, valid in the cycle mem_ready = 1

Behaviour:
- Reset values: busy=0, done=0, error=0, xfer_count=0, mem_valid=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, state IDLE.
- Reset mid-job: the job is abandoned immediately, with no further bus cycles.
- All outputs are registered.

Bus rules:
- While mem_valid=1, mem_addr, mem_wstrb and mem_wdata are held stable until mem_ready is sampled high.
- mem_ready is ignored while mem_valid=0.
- After each completed transfer, mem_valid=0 for exactly one cycle (GAP). Responders register ready from valid, so this gap absorbs the trailing ready.
- Whenever mem_valid=0, mem_wstrb=0 and mem_wdata=0, so that no write strobes leak to responders that write without qualifying on valid.

States:
- IDLE: on start, latch inputs with bits[1:0] cleared, set xfer_count=0 and error=0.
  - If len=0: done=1 the next cycle, busy stays 0, state stays IDLE, no bus cycle.
  - Else: busy=1, go to READ (fill=0) or WRITE (fill=1).
  - start while busy is ignored.
- READ: mem_valid=1, mem_wstrb=0, mem_addr=src. On mem_ready: latch mem_rdata into the data buffer, src+=4, go to GAP_R.
- GAP_R: mem_valid=0 for one cycle, then go to WRITE.
- WRITE: mem_valid=1, mem_wstrb=4'hF, mem_addr=dst, mem_wdata = buffer (copy) or pattern (fill). On mem_ready: dst+=4, xfer_count+=1.
  - If this was the last word: go to DONE.
  - Else: go to GAP_W.
- GAP_W: mem_valid=0 for one cycle, then go to READ (copy) or WRITE (fill).
- DONE: done=1 for one cycle, busy=0 in the same cycle, then go to IDLE.
- ERR: entered from READ or WRITE when the wait counter reaches TIMEOUT with no mem_ready.
  - mem_valid drops, error=1, busy=0, done stays 0, go to IDLE.
  - xfer_count keeps the words completed before the timeout.

Arithmetic and timing:
- Addresses increment modulo 2^32 (0xFFFFFFFC + 4 wraps to 0x00000000).
- len = 2^LEN_W - 1 is supported.
- The wait counter resets at every entry to READ or WRITE.
- With a zero-wait responder (ready one cycle after valid):
  - copy takes 6 cycles per word;
  - fill takes 3 cycles per word;
  - done asserts 1 cycle after the final write completes.
- Overlapping regions are copied in ascending address order; there is no overlap correction.

Test Plan:
- Copy, len=4, src=0x100, dst=0x200, RAM preloaded 0x11111111..0x44444444 -> words 0x200..0x20C match; done pulses once; xfer_count=4; 24 cycles start-to-done (+/-1); no write strobe while valid=0.
- Fill, len=3, dst=0x40, pattern=0xDEADBEEF -> 0x40/0x44/0x48 = 0xDEADBEEF; no read cycles issued; 0x4C unchanged.
- len=0 start -> done pulse the next cycle; busy never high; mem_valid never high.
- Responder stalls ready forever on the 2nd read, TIMEOUT=16 -> mem_valid drops 16 cycles after that read's valid rises; error=1; xfer_count=1; done=0; the next start clears error.
- Address wrap: dst=0xFFFFFFF8, fill, len=3 -> writes hit 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; src/dst with bits[1:0]=2'b11 -> mem_addr[1:0] is always 0.
- Reset asserted mid-write of word 2 of 5 -> mem_valid=0, busy=0 and all outputs at reset values the next cycle; a start pulse while busy is ignored and the job completes unchanged.

Source files
------------

// File: rtl/mem_copy_dma.sv
// Memory copy / fill DMA initiator for the native valid/ready memory bus.
// One transfer is outstanding at a time, and every completed transfer is
// followed by a single idle cycle that absorbs the responder's trailing ready.
module mem_copy_dma #(
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             fill,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len,
    input  logic [31:0]      pattern,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [LEN_W-1:0] xfer_count,
    output logic             mem_valid,
    input  logic             mem_ready,
    output logic [3:0]       mem_wstrb,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata
);

    localparam int unsigned WAIT_W     = $clog2(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] WORD_STEP  = 32'd4;
    localparam logic [3:0]  STRB_WRITE = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_GAP_R,
        S_WRITE,
        S_GAP_W,
        S_DONE,
        S_ERR
    } state_t;

    state_t state, state_d;

    logic [31:0]       src_q, src_d;
    logic [31:0]       dst_q, dst_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              fill_q, fill_d;
    logic [31:0]       pattern_q, pattern_d;
    logic [31:0]       buf_q, buf_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic              busy_d, done_d, error_d, mem_valid_d;
    logic [LEN_W-1:0]  xfer_count_d;
    logic [3:0]        mem_wstrb_d;
    logic [31:0]       mem_addr_d, mem_wdata_d;

    logic [LEN_W-1:0]  cnt_inc;
    logic [31:0]       src_align, dst_align;

    assign cnt_inc   = xfer_count + LEN_W'(1);
    assign src_align = src_addr & ALIGN_MASK;
    assign dst_align = dst_addr & ALIGN_MASK;

    // State, job context and all outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            fill_q     <= 1'b0;
            pattern_q  <= '0;
            buf_q      <= '0;
            wait_q     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            xfer_count <= '0;
            mem_valid  <= 1'b0;
            mem_wstrb  <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            state      <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            len_q      <= len_d;
            fill_q     <= fill_d;
            pattern_q  <= pattern_d;
            buf_q      <= buf_d;
            wait_q     <= wait_d;
            busy       <= busy_d;
            done       <= done_d;
            error      <= error_d;
            xfer_count <= xfer_count_d;
            mem_valid  <= mem_valid_d;
            mem_wstrb  <= mem_wstrb_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
        end
    end

    // Next-state and next-output logic; the bus defaults to idle with zero strobes and data.
    always_comb begin
        state_d      = state;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        fill_d       = fill_q;
        pattern_d    = pattern_q;
        buf_d        = buf_q;
        wait_d       = '0;
        busy_d       = busy;
        done_d       = 1'b0;
        error_d      = error;
        xfer_count_d = xfer_count;
        mem_valid_d  = 1'b0;
        mem_wstrb_d  = '0;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = '0;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    src_d        = src_align;
                    dst_d        = dst_align;
                    len_d        = len;
                    fill_d       = fill;
                    pattern_d    = pattern;
                    xfer_count_d = '0;
                    error_d      = 1'b0;
                    if (len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        busy_d      = 1'b1;
                        mem_valid_d = 1'b1;
                        if (fill) begin
                            state_d     = S_WRITE;
                            mem_wstrb_d = STRB_WRITE;
                            mem_addr_d  = dst_align;
                            mem_wdata_d = pattern;
                        end else begin
                            state_d    = S_READ;
                            mem_addr_d = src_align;
                        end
                    end
                end
            end

            S_READ: begin
                if (mem_ready) begin
                    buf_d   = mem_rdata;
                    src_d   = src_q + WORD_STEP;
                    state_d = S_GAP_R;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    wait_d      = wait_q + WAIT_W'(1);
                    mem_valid_d = 1'b1;
                end
            end

            S_GAP_R: begin
                state_d     = S_WRITE;
                mem_valid_d = 1'b1;
                mem_wstrb_d = STRB_WRITE;
                mem_addr_d  = dst_q;
                mem_wdata_d = buf_q;
            end

            S_WRITE: begin
                if (mem_ready) begin
                    dst_d        = dst_q + WORD_STEP;
                    xfer_count_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = S_GAP_W;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    wait_d      = wait_q + WAIT_W'(1);
                    mem_valid_d = 1'b1;
                    mem_wstrb_d = mem_wstrb;
                    mem_wdata_d = mem_wdata;
                end
            end

            S_GAP_W: begin
                mem_valid_d = 1'b1;
                if (fill_q) begin
                    state_d     = S_WRITE;
                    mem_wstrb_d = STRB_WRITE;
                    mem_addr_d  = dst_q;
                    mem_wdata_d = pattern_q;
                end else begin
                    state_d    = S_READ;
                    mem_addr_d = src_q;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            S_ERR: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copy_dma.sv
// Directed bench for mem_copy_dma with a registered-ready RAM responder.
module tb_mem_copy_dma;

    localparam int unsigned LEN_W   = 16;
    localparam int unsigned TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             fill = 1'b0;
    logic [31:0]      src_addr = '0;
    logic [31:0]      dst_addr = '0;
    logic [LEN_W-1:0] len = '0;
    logic [31:0]      pattern = '0;
    logic             busy, done, error;
    logic [LEN_W-1:0] xfer_count;
    logic             mem_valid;
    logic             mem_ready;
    logic [3:0]       mem_wstrb;
    logic [31:0]      mem_addr, mem_wdata;
    logic [31:0]      mem_rdata;

    mem_copy_dma #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .fill       (fill),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len        (len),
        .pattern    (pattern),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .xfer_count (xfer_count),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_wstrb  (mem_wstrb),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    // Responder and bus monitor state, written only by the posedge block.
    logic [31:0] ram [0:1023];
    logic [31:0] wr_log [0:7];
    int          cyc = 0;
    int          rd_cnt = 0, wr_cnt = 0;
    int          leak_cnt = 0, mis_cnt = 0, stab_cnt = 0;
    int          vhi = 0, bhi = 0, done_cnt = 0;
    int          rise_cyc = 0, fall_cyc = 0, done_cyc = 0;
    logic        pv = 1'b0, pr = 1'b0;
    logic [31:0] pa = '0, pd = '0;
    logic [3:0]  ps = '0;

    // Controls driven by the stimulus process.
    logic        stall_en = 1'b0;
    int          stall_at = 0;
    logic        ld_en = 1'b0;
    logic [31:0] ld_a = '0, ld_d = '0;

    // RAM responder: ready registered from valid, plus protocol monitors.
    always @(posedge clk) begin
        cyc       <= cyc + 1;
        mem_ready <= mem_valid && !(stall_en && mem_wstrb == 4'h0 && rd_cnt >= stall_at);
        mem_rdata <= ram[mem_addr[11:2]];
        if (ld_en) ram[ld_a[11:2]] <= ld_d;
        if (mem_valid && mem_ready) begin
            if (mem_wstrb == 4'hF) begin
                ram[mem_addr[11:2]] <= mem_wdata;
                wr_log[wr_cnt[2:0]] <= mem_addr;
                wr_cnt <= wr_cnt + 1;
            end else begin
                rd_cnt <= rd_cnt + 1;
            end
        end
        if (!mem_valid && (mem_wstrb != 4'h0 || mem_wdata != 32'h0)) leak_cnt <= leak_cnt + 1;
        if (mem_addr[1:0] != 2'b00) mis_cnt <= mis_cnt + 1;
        if (pv && !pr && mem_valid && (mem_addr != pa || mem_wstrb != ps || mem_wdata != pd))
            stab_cnt <= stab_cnt + 1;
        if (mem_valid) vhi <= vhi + 1;
        if (mem_valid && !pv) rise_cyc <= cyc;
        if (!mem_valid && pv) fall_cyc <= cyc;
        if (busy) bhi <= bhi + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        pv <= mem_valid;
        pr <= mem_ready;
        pa <= mem_addr;
        ps <= mem_wstrb;
        pd <= mem_wdata;
    end

    task automatic ram_load(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_en = 1'b1;
        ld_a  = a;
        ld_d  = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic do_start(input logic f, input logic [31:0] s, input logic [31:0] d,
                            input logic [31:0] p, input logic [LEN_W-1:0] n, output int sc);
        @(negedge clk);
        fill     = f;
        src_addr = s;
        dst_addr = d;
        pattern  = p;
        len      = n;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sc    = cyc - 1;
    endtask

    task automatic wait_end(input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done || error) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if ({busy, done, error, xfer_count, mem_valid, mem_wstrb, mem_addr, mem_wdata} !== '0) begin
            mismatched++;
            $display("FAIL reset_values: busy=%b done=%b error=%b xfer=%0d valid=%b wstrb=%h addr=%h wdata=%h, want all 0",
                     busy, done, error, xfer_count, mem_valid, mem_wstrb, mem_addr, mem_wdata);
        end
        reset = 1'b0;
        ram_load(32'h100, 32'h1111_1111);
        ram_load(32'h104, 32'h2222_2222);
        ram_load(32'h108, 32'h3333_3333);
        ram_load(32'h10C, 32'h4444_4444);
        ram_load(32'h110, 32'h5555_5555);
        ram_load(32'h04C, 32'h5A5A_5A5A);
        ram_load(32'h3C0, 32'h0000_0000);
    endtask

    task automatic test_copy;
        int sc, d0, l0, s0;
        bit to;
        logic [31:0] exp_w [0:3];
        exp_w[0] = 32'h1111_1111;
        exp_w[1] = 32'h2222_2222;
        exp_w[2] = 32'h3333_3333;
        exp_w[3] = 32'h4444_4444;
        d0 = done_cnt; l0 = leak_cnt; s0 = stab_cnt;
        do_start(1'b0, 32'h100, 32'h200, 32'h0, 16'd4, sc);
        wait_end(100, to);
        compared++;
        if (to) begin mismatched++; $display("FAIL copy_end: no done/error within 100 cycles"); end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            compared++;
            if (ram[10'(32'h80 + i)] !== exp_w[i]) begin
                mismatched++;
                $display("FAIL copy_word%0d: got %h, want %h", i, ram[10'(32'h80 + i)], exp_w[i]);
            end
        end
        compared++;
        if (done_cnt - d0 != 1) begin mismatched++; $display("FAIL copy_done_pulses: got %0d, want 1", done_cnt - d0); end
        compared++;
        if (done_cyc - sc < 23 || done_cyc - sc > 25) begin
            mismatched++; $display("FAIL copy_latency: got %0d cycles, want 24 (+/-1)", done_cyc - sc);
        end
        compared++;
        if (xfer_count !== 16'd4) begin mismatched++; $display("FAIL copy_xfer: got %0d, want 4", xfer_count); end
        compared++;
        if (busy !== 1'b0 || error !== 1'b0) begin
            mismatched++; $display("FAIL copy_flags: busy=%b error=%b, want 0 0", busy, error);
        end
        compared++;
        if (leak_cnt != l0 || stab_cnt != s0) begin
            mismatched++; $display("FAIL copy_bus_rules: leaks=%0d unstable=%0d, want 0 0", leak_cnt - l0, stab_cnt - s0);
        end
    endtask

    task automatic test_fill;
        int sc, r0, w0;
        bit to;
        r0 = rd_cnt; w0 = wr_cnt;
        do_start(1'b1, 32'h0, 32'h40, 32'hDEAD_BEEF, 16'd3, sc);
        wait_end(100, to);
        compared++;
        if (to) begin mismatched++; $display("FAIL fill_end: no done/error within 100 cycles"); end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (ram[10'(32'h10 + i)] !== 32'hDEAD_BEEF) begin
                mismatched++; $display("FAIL fill_word%0d: got %h, want deadbeef", i, ram[10'(32'h10 + i)]);
            end
        end
        compared++;
        if (ram[10'h13] !== 32'h5A5A_5A5A) begin mismatched++; $display("FAIL fill_beyond: got %h, want 5a5a5a5a", ram[10'h13]); end
        compared++;
        if (rd_cnt != r0 || wr_cnt - w0 != 3) begin
            mismatched++; $display("FAIL fill_bus_count: reads=%0d writes=%0d, want 0 3", rd_cnt - r0, wr_cnt - w0);
        end
        compared++;
        if (done_cyc - sc != 9) begin mismatched++; $display("FAIL fill_latency: got %0d cycles, want 9", done_cyc - sc); end
        compared++;
        if (xfer_count !== 16'd3) begin mismatched++; $display("FAIL fill_xfer: got %0d, want 3", xfer_count); end
    endtask

    task automatic test_len0;
        int sc, b0, v0, d0;
        b0 = bhi; v0 = vhi; d0 = done_cnt;
        do_start(1'b0, 32'h100, 32'h200, 32'h0, 16'd0, sc);
        compared++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            mismatched++; $display("FAIL len0_done: done=%b busy=%b, want 1 0", done, busy);
        end
        @(negedge clk);
        compared++;
        if (done !== 1'b0) begin mismatched++; $display("FAIL len0_pulse: done=%b, want 0", done); end
        repeat (3) @(negedge clk);
        compared++;
        if (bhi != b0 || vhi != v0 || done_cnt - d0 != 1) begin
            mismatched++; $display("FAIL len0_quiet: busy_cycles=%0d valid_cycles=%0d dones=%0d, want 0 0 1",
                                   bhi - b0, vhi - v0, done_cnt - d0);
        end
    endtask

    task automatic test_timeout;
        int sc, d0;
        bit to;
        stall_at = rd_cnt + 1;
        stall_en = 1'b1;
        d0 = done_cnt;
        do_start(1'b0, 32'h100, 32'h300, 32'h0, 16'd3, sc);
        wait_end(200, to);
        compared++;
        if (to) begin mismatched++; $display("FAIL tmo_end: no done/error within 200 cycles"); end
        repeat (2) @(negedge clk);
        compared++;
        if (error !== 1'b1 || busy !== 1'b0 || mem_valid !== 1'b0) begin
            mismatched++; $display("FAIL tmo_flags: error=%b busy=%b valid=%b, want 1 0 0", error, busy, mem_valid);
        end
        compared++;
        if (xfer_count !== 16'd1) begin mismatched++; $display("FAIL tmo_xfer: got %0d, want 1", xfer_count); end
        compared++;
        if (fall_cyc - rise_cyc != 16) begin
            mismatched++; $display("FAIL tmo_window: valid high %0d cycles, want 16", fall_cyc - rise_cyc);
        end
        compared++;
        if (done_cnt != d0) begin mismatched++; $display("FAIL tmo_done: got %0d pulses, want 0", done_cnt - d0); end
        stall_en = 1'b0;
        do_start(1'b1, 32'h0, 32'h3E0, 32'h0BAD_F00D, 16'd1, sc);
        compared++;
        if (error !== 1'b0) begin mismatched++; $display("FAIL tmo_clear: error=%b, want 0", error); end
        wait_end(50, to);
        repeat (2) @(negedge clk);
        compared++;
        if (to || ram[10'hF8] !== 32'h0BAD_F00D) begin
            mismatched++; $display("FAIL tmo_recover: timeout=%b word=%h, want 0 0badf00d", to, ram[10'hF8]);
        end
    endtask

    task automatic test_wrap;
        int sc, w0, m0;
        bit to;
        logic [31:0] exp_a [0:2];
        exp_a[0] = 32'hFFFF_FFF8;
        exp_a[1] = 32'hFFFF_FFFC;
        exp_a[2] = 32'h0000_0000;
        w0 = wr_cnt; m0 = mis_cnt;
        do_start(1'b1, 32'h0, 32'hFFFF_FFF8, 32'hC0FF_EE00, 16'd3, sc);
        wait_end(100, to);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            compared++;
            if (to || wr_log[(w0 + i) % 8] !== exp_a[i]) begin
                mismatched++; $display("FAIL wrap_addr%0d: got %h, want %h", i, wr_log[(w0 + i) % 8], exp_a[i]);
            end
        end
        do_start(1'b0, 32'h103, 32'h2F3, 32'h0, 16'd2, sc);
        wait_end(100, to);
        repeat (2) @(negedge clk);
        compared++;
        if (to || ram[10'hBC] !== 32'h1111_1111 || ram[10'hBD] !== 32'h2222_2222) begin
            mismatched++; $display("FAIL align_copy: got %h %h, want 11111111 22222222", ram[10'hBC], ram[10'hBD]);
        end
        compared++;
        if (mis_cnt != m0) begin mismatched++; $display("FAIL align_addr: %0d misaligned cycles, want 0", mis_cnt - m0); end
    endtask

    task automatic test_reset_mid;
        int sc, w0, w1, v0;
        bit found;
        w0 = wr_cnt;
        found = 1'b0;
        do_start(1'b0, 32'h100, 32'h380, 32'h0, 16'd5, sc);
        for (int i = 0; i < 60; i++) begin
            if (wr_cnt - w0 == 1 && mem_valid && mem_wstrb == 4'hF) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        compared++;
        if (!found) begin mismatched++; $display("FAIL rstmid_reach: second write not seen within 60 cycles"); end
        reset = 1'b1;
        @(negedge clk);
        compared++;
        if ({busy, done, error, xfer_count, mem_valid, mem_wstrb, mem_addr, mem_wdata} !== '0) begin
            mismatched++;
            $display("FAIL rstmid_values: busy=%b done=%b error=%b xfer=%0d valid=%b wstrb=%h addr=%h wdata=%h, want all 0",
                     busy, done, error, xfer_count, mem_valid, mem_wstrb, mem_addr, mem_wdata);
        end
        v0 = vhi; w1 = wr_cnt;
        @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        compared++;
        if (vhi != v0 || wr_cnt != w1 || busy !== 1'b0) begin
            mismatched++; $display("FAIL rstmid_quiet: valid_cycles=%0d writes=%0d busy=%b, want 0 0 0",
                                   vhi - v0, wr_cnt - w1, busy);
        end
    endtask

    task automatic test_back_to_back;
        int sc, r0;
        bit to;
        r0 = rd_cnt;
        do_start(1'b0, 32'h100, 32'h3A0, 32'h0, 16'd2, sc);
        repeat (3) @(negedge clk);
        fill     = 1'b1;
        dst_addr = 32'h3C0;
        len      = 16'd1;
        pattern  = 32'hBAD0_BAD0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_end(100, to);
        repeat (2) @(negedge clk);
        compared++;
        if (to || ram[10'hE8] !== 32'h1111_1111 || ram[10'hE9] !== 32'h2222_2222) begin
            mismatched++; $display("FAIL b2b_copy: got %h %h, want 11111111 22222222", ram[10'hE8], ram[10'hE9]);
        end
        compared++;
        if (ram[10'hF0] !== 32'h0) begin mismatched++; $display("FAIL b2b_ignored: got %h, want 0", ram[10'hF0]); end
        compared++;
        if (xfer_count !== 16'd2 || rd_cnt - r0 != 2) begin
            mismatched++; $display("FAIL b2b_counts: xfer=%0d reads=%0d, want 2 2", xfer_count, rd_cnt - r0);
        end
        compared++;
        if (done_cyc - sc != 12) begin mismatched++; $display("FAIL b2b_latency: got %0d cycles, want 12", done_cyc - sc); end
    endtask

    initial begin
        test_reset;
        test_copy;
        test_fill;
        test_len0;
        test_timeout;
        test_wrap;
        test_reset_mid;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
